fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined datapath; sits beside ID/EX.
- Keeps its own shadow pipeline of destination tags: dest register, write-enable and load flag per downstream stage.
- Produces per-operand forward selects for NUM_SRC operands and the load-use stall/bubble request.
- Generalises the fixed two-stage, two-operand forwarding logic to arbitrary depth, operand count and load latency, and adds a stall-cycle performance counter.

---
 rtl/fwd_hazard_unit_pkg.sv | 28 ++
 rtl/fwd_match_prio.sv | 31 +++
 rtl/fwd_hazard_unit.sv | 66 ++++++
 tb/tb_fwd_hazard_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared tag types for the forwarding / hazard unit.
// Tag entries mirror the dest-register view of each downstream stage.
package fwd_pkg;

  localparam int TAG_AW_MAX = 8;
  localparam int FSEL_RF = 0;

  typedef struct packed {
    logic                  we;
    logic                  load;
    logic [TAG_AW_MAX-1:0] dest;
  } tag_t;

  localparam tag_t BUBBLE = '0;

  function automatic tag_t mk_tag(
    input logic                  we,
    input logic                  load,
    input logic [TAG_AW_MAX-1:0] dest
  );
    tag_t t;
    t.we   = we;
    t.load = load;
    t.dest = dest;
    return t;
  endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// Youngest-producer search for one source operand.
// Also flags a load whose data is not yet forwardable.
import fwd_pkg::*;

module fwd_match_prio #(
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int FSEL_W     = 2
) (
  input  tag_t [DEPTH:1]        ent,
  input  logic [TAG_AW_MAX-1:0] src,
  input  logic                  used,
  input  logic                  valid,
  output logic [FSEL_W-1:0]     sel,
  output logic                  hazard
);

  // Scan oldest to youngest so the youngest match is the last write.
  always_comb begin
    sel    = FSEL_W'(FSEL_RF);
    hazard = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid && used && ent[k].we &&
          ent[k].dest != '0 && ent[k].dest == src) begin
        sel    = FSEL_W'(k);
        hazard = ent[k].load && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation beside ID/EX.
// Shadow tag pipeline, stall priority update and stall counter.
import fwd_pkg::*;

module fwd_hazard_unit #(
  parameter int REG_AW     = 3,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int FSEL_W    = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      hold,
  input  logic                      flush,
  output logic [NUM_SRC*FSEL_W-1:0] fwd_sel,
  output logic                      load_use_stall,
  output logic [CNT_W-1:0]          stall_cycles
);

  tag_t [DEPTH:1]     ent_q;
  logic [NUM_SRC-1:0] hz;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match_prio #(
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .FSEL_W     (FSEL_W)
    ) u_match (
      .ent    (ent_q),
      .src    (TAG_AW_MAX'(id_src[i*REG_AW +: REG_AW])),
      .used   (id_src_used[i]),
      .valid  (id_valid),
      .sel    (fwd_sel[i*FSEL_W +: FSEL_W]),
      .hazard (hz[i])
    );
  end

  assign load_use_stall = (|hz) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q        <= '0;
      stall_cycles <= '0;
    end else if (!hold) begin
      if (flush || load_use_stall)
        ent_q[1] <= BUBBLE;
      else
        ent_q[1] <= mk_tag(id_valid & id_reg_write,
                           id_valid & id_mem_read,
                           TAG_AW_MAX'(id_dest));
      for (int k = 2; k <= DEPTH; k++)
        ent_q[k] <= ent_q[k-1];
      if (load_use_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised and directed checks of fwd_hazard_unit against a
// behavioural model, on a default and a deep/late-load instance.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic [2:0] id_dest = '0;
  logic [5:0] id_src = '0;
  logic [1:0] id_src_used = '0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;

  logic [3:0]  sel_a, sel_b;
  logic        st_a, st_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_AW(3), .NUM_SRC(2), .DEPTH(2), .LOAD_STAGE(2), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .id_src(id_src), .id_src_used(id_src_used),
    .hold(hold), .flush(flush), .fwd_sel(sel_a),
    .load_use_stall(st_a), .stall_cycles(cnt_a)
  );

  fwd_hazard_unit #(
    .REG_AW(3), .NUM_SRC(2), .DEPTH(3), .LOAD_STAGE(3), .CNT_W(3)
  ) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .id_src(id_src), .id_src_used(id_src_used),
    .hold(hold), .flush(flush), .fwd_sel(sel_b),
    .load_use_stall(st_b), .stall_cycles(cnt_b)
  );

  // Model: per instance, the producers sitting in stages 1..depth.
  int dep[2]  = '{2, 3};
  int ls[2]   = '{2, 3};
  int cmax[2] = '{65535, 7};
  bit mw[2][4];
  bit ml[2][4];
  int md[2][4];
  int cnt[2];

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) begin
        mw[n][k] = 0; ml[n][k] = 0; md[n][k] = 0;
      end
      cnt[n] = 0;
    end
  endtask

  function automatic int xsel(int n, int i);
    int s;
    s = int'(id_src[i*3 +: 3]);
    for (int k = 1; k <= dep[n]; k++)
      if (id_valid && id_src_used[i] && mw[n][k] &&
          md[n][k] != 0 && md[n][k] == s)
        return k;
    return 0;
  endfunction

  function automatic bit xhz(int n, int i);
    int k;
    k = xsel(n, i);
    return k != 0 && ml[n][k] && k < ls[n];
  endfunction

  function automatic bit xst(int n);
    return (xhz(n, 0) || xhz(n, 1)) && !flush;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] xsel_pk(int n);
    return {2'(xsel(n, 1)), 2'(xsel(n, 0))};
  endfunction

  task automatic compare_all();
    chk("sel_a", 32'(sel_a), 32'(xsel_pk(0)));
    chk("stall_a", 32'(st_a), 32'(xst(0)));
    chk("cnt_a", 32'(cnt_a), 32'(cnt[0]));
    chk("sel_b", 32'(sel_b), 32'(xsel_pk(1)));
    chk("stall_b", 32'(st_b), 32'(xst(1)));
    chk("cnt_b", 32'(cnt_b), 32'(cnt[1]));
  endtask

  task automatic probe();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    bit s[2];
    for (int n = 0; n < 2; n++) s[n] = xst(n);
    if (!hold) begin
      for (int n = 0; n < 2; n++) begin
        for (int k = dep[n]; k >= 2; k--) begin
          mw[n][k] = mw[n][k-1];
          ml[n][k] = ml[n][k-1];
          md[n][k] = md[n][k-1];
        end
        if (s[n] || flush) begin
          mw[n][1] = 0; ml[n][1] = 0; md[n][1] = 0;
        end else begin
          mw[n][1] = id_valid && id_reg_write;
          ml[n][1] = id_valid && id_mem_read;
          md[n][1] = int'(id_dest);
        end
        if (s[n] && cnt[n] < cmax[n]) cnt[n]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit v, bit rw, bit mr, int d, int s0, int s1,
                        int used, bit h, bit f);
    id_valid = v; id_reg_write = rw; id_mem_read = mr;
    id_dest = 3'(d); id_src = {3'(s1), 3'(s0)};
    id_src_used = 2'(used); hold = h; flush = f;
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b1;
    @(posedge clk); #1;

    probe();
    chk("rst_sel", 32'(sel_a), 0);
    chk("rst_stall", 32'(st_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);

    // back-to-back ALU forwarding
    set_in(1, 1, 0, 3, 1, 2, 3, 0, 0); probe(); adv();
    set_in(1, 0, 0, 0, 3, 1, 3, 0, 0); probe();
    chk("b2b_stage1", 32'(sel_a[1:0]), 1); adv();
    set_in(1, 1, 0, 6, 3, 1, 3, 0, 0); probe();
    chk("b2b_stage2", 32'(sel_a[1:0]), 2); adv();

    // double producer, youngest wins
    set_in(1, 1, 0, 5, 1, 1, 0, 0, 0); probe(); adv();
    set_in(1, 1, 0, 5, 1, 1, 0, 0, 0); probe(); adv();
    set_in(1, 0, 0, 0, 5, 5, 3, 0, 0); probe();
    chk("double_prod", 32'(sel_a), 32'h5); adv();

    // load-use, one bubble on the default instance
    set_in(1, 1, 1, 4, 0, 0, 0, 0, 0); probe(); adv();
    set_in(1, 1, 0, 1, 4, 1, 1, 0, 0); probe();
    chk("lu_stall", 32'(st_a), 1); adv();
    probe();
    chk("lu_clear", 32'(st_a), 0);
    chk("lu_fwd2", 32'(sel_a[1:0]), 2);
    chk("lu_cnt", 32'(cnt_a), 1); adv();

    // register 0 and unused operand never forward
    set_in(1, 1, 0, 0, 1, 1, 0, 0, 0); probe(); adv();
    set_in(1, 1, 0, 2, 0, 1, 1, 0, 0); probe();
    chk("r0_nofwd", 32'(sel_a[1:0]), 0); adv();
    set_in(1, 0, 0, 0, 1, 2, 1, 0, 0); probe();
    chk("unused_src", 32'(sel_a[3:2]), 0);
    id_src_used = 2'b11; #1;
    chk("used_src", 32'(sel_a[3:2]), 1); adv();

    // hold freezes a pending hazard
    set_in(1, 1, 1, 4, 0, 0, 0, 0, 0); probe(); adv();
    set_in(1, 1, 0, 1, 4, 1, 1, 1, 0); probe();
    chk("hold_stall", 32'(st_a), 1); adv();
    probe();
    chk("hold_stall2", 32'(st_a), 1);
    chk("hold_cnt", 32'(cnt_a), 1); adv();
    hold = 0; probe(); adv();
    probe();
    chk("hold_after", 32'(cnt_a), 2); adv();

    // flush masks the stall and inserts a bubble
    set_in(1, 1, 1, 6, 0, 0, 0, 0, 0); probe(); adv();
    set_in(1, 1, 0, 1, 6, 1, 1, 0, 1); probe();
    chk("flush_stall", 32'(st_a), 0); adv();
    set_in(1, 1, 0, 1, 6, 1, 1, 0, 0); probe();
    chk("flush_fwd2", 32'(sel_a[1:0]), 2);
    chk("flush_nostall", 32'(st_a), 0); adv();

    // asynchronous reset in the middle of a stall
    set_in(1, 1, 1, 4, 0, 0, 0, 0, 0); probe(); adv();
    set_in(1, 1, 0, 1, 4, 1, 1, 0, 0); probe();
    chk("pre_rst_stall", 32'(st_a), 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_sel", 32'(sel_a), 0);
    chk("arst_stall", 32'(st_a), 0);
    chk("arst_cnt", 32'(cnt_a), 0);
    @(posedge clk); #2 rst = 1'b1;
    probe();
    chk("post_rst_stall", 32'(st_a), 0); adv();

    // four load-use pairs: 4 stalls on a, 8 on b (saturates at 7)
    for (int p = 0; p < 4; p++) begin
      set_in(1, 1, 1, 4, 0, 0, 0, 0, 0); probe(); adv();
      set_in(1, 1, 0, 1, 4, 1, 1, 0, 0);
      for (int c = 0; c < 3; c++) begin probe(); adv(); end
    end
    probe();
    chk("sat_cnt_a", 32'(cnt_a), 4);
    chk("sat_cnt_b", 32'(cnt_b), 7); adv();

    for (int r = 0; r < 2000; r++) begin
      id_valid     = $urandom_range(0, 9) != 0;
      id_reg_write = $urandom_range(0, 3) != 0;
      id_mem_read  = id_reg_write && ($urandom_range(0, 2) == 0);
      id_dest      = 3'($urandom);
      id_src       = 6'($urandom);
      id_src_used  = 2'($urandom);
      hold         = $urandom_range(0, 9) == 0;
      flush        = $urandom_range(0, 9) == 0;
      probe();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
